// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_pkg
//  Description : Shared constants for the MM2S stream receiver.
//  Revision    : 1.0  initial release
// ============================================================================
package stream_pkg;

    localparam int c_data_w_def       = 64;
    localparam int c_cnt_w_def        = 13;
    localparam int c_afull_margin_min = 3;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_recv  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/stream_rx.sv
`default_nettype none
// ============================================================================
//  Module      : stream_rx
//  Description : AXI4-Stream MM2S receiver writing beats into the frame
//                buffer FIFO, with length checking and fill backpressure.
//  Revision    : 1.0  initial release
// ============================================================================
module stream_rx
    import stream_pkg::*;
#(
    parameter int DATA_W       = c_data_w_def,
    parameter int CNT_W        = c_cnt_w_def,
    parameter int BUF_DEPTH    = 4096,
    parameter int AFULL_MARGIN = 8
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic [DATA_W-1:0] m_axis_mm2s_tdata,
    input  logic              m_axis_mm2s_tvalid,
    output logic              m_axis_mm2s_tready,
    input  logic              m_axis_mm2s_tlast,
    output logic              buffer_wr_en,
    output logic [DATA_W-1:0] buffer_wr_data,
    input  logic [CNT_W-1:0]  buffer_data_count,
    input  logic              rx_start,
    input  logic [CNT_W-1:0]  rx_len,
    output logic              rx_busy,
    output logic              write_finish,
    output logic              len_err
);

    // A margin below the minimum cannot absorb the two in-flight beats.
    localparam int c_margin = (AFULL_MARGIN < c_afull_margin_min) ? c_afull_margin_min : AFULL_MARGIN;
    localparam logic [CNT_W-1:0] c_afull_thresh = CNT_W'(BUF_DEPTH - c_margin);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [CNT_W-1:0]  r_rx_len;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              r_afull;
    logic              r_tready;
    logic              r_wr_en;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_busy;
    logic              r_write_finish;
    logic              r_len_err;
    logic              w_accept;
    logic              w_start;
    logic              w_hit_len;
    logic              w_len_err_set;
    logic              w_recv_beat;

    always_comb begin
        w_accept      = m_axis_mm2s_tvalid && r_tready;
        w_start       = (r_state == c_st_idle) && rx_start && (rx_len != '0);
        w_recv_beat   = (r_state == c_st_recv) && w_accept;
        w_cnt_inc     = r_beat_cnt + CNT_W'(1);
        w_hit_len     = (w_cnt_inc == r_rx_len);
        w_next        = r_state;
        w_len_err_set = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_start) w_next = c_st_recv;
            end
            c_st_recv: begin
                if (w_accept) begin
                    if (m_axis_mm2s_tlast) begin
                        w_next        = c_st_done;
                        w_len_err_set = !w_hit_len;
                    end else if (w_hit_len) begin
                        w_next        = c_st_drain;
                        w_len_err_set = 1'b1;
                    end
                end
            end
            c_st_drain: begin
                if (w_accept && m_axis_mm2s_tlast) w_next = c_st_done;
            end
            default: w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state        <= c_st_idle;
            r_beat_cnt     <= '0;
            r_rx_len       <= '0;
            r_afull        <= 1'b0;
            r_tready       <= 1'b0;
            r_wr_en        <= 1'b0;
            r_wr_data      <= '0;
            r_busy         <= 1'b0;
            r_write_finish <= 1'b0;
            r_len_err      <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_afull        <= (buffer_data_count >= c_afull_thresh);
            // Ready follows the state being entered, so it drops on the leaving beat.
            r_tready       <= ((w_next == c_st_recv) && !r_afull) || (w_next == c_st_drain);
            r_wr_en        <= w_recv_beat;
            if (w_recv_beat) r_wr_data <= m_axis_mm2s_tdata;
            r_write_finish <= (w_next == c_st_done);
            r_busy         <= (w_next != c_st_idle);
            if (w_start) begin
                r_rx_len   <= rx_len;
                r_beat_cnt <= '0;
                r_len_err  <= 1'b0;
            end else begin
                if (w_recv_beat)   r_beat_cnt <= w_cnt_inc;
                if (w_len_err_set) r_len_err  <= 1'b1;
            end
        end
    end

    assign m_axis_mm2s_tready = r_tready;
    assign buffer_wr_en       = r_wr_en;
    assign buffer_wr_data     = r_wr_data;
    assign rx_busy            = r_busy;
    assign write_finish       = r_write_finish;
    assign len_err            = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_stream_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_rx
//  Description : Directed self-checking bench for stream_rx.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stream_rx;

    logic        sclk;
    logic        s_rst_n;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        wr_en;
    logic [63:0] wr_data;
    logic [12:0] data_count;
    logic        rx_start;
    logic [12:0] rx_len;
    logic        rx_busy;
    logic        write_finish;
    logic        len_err;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int fin_cnt = 0;
    int w0;
    int f0;

    stream_rx #(
        .DATA_W(64), .CNT_W(13), .BUF_DEPTH(4096), .AFULL_MARGIN(8)
    ) u_dut (
        .sclk               (sclk),
        .s_rst_n            (s_rst_n),
        .m_axis_mm2s_tdata  (tdata),
        .m_axis_mm2s_tvalid (tvalid),
        .m_axis_mm2s_tready (tready),
        .m_axis_mm2s_tlast  (tlast),
        .buffer_wr_en       (wr_en),
        .buffer_wr_data     (wr_data),
        .buffer_data_count  (data_count),
        .rx_start           (rx_start),
        .rx_len             (rx_len),
        .rx_busy            (rx_busy),
        .write_finish       (write_finish),
        .len_err            (len_err)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    always @(negedge sclk) begin
        if (wr_en)        wr_cnt  <= wr_cnt + 1;
        if (write_finish) fin_cnt <= fin_cnt + 1;
    end

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input int len);
        rx_start = 1'b1;
        rx_len   = 13'(len);
        step();
        rx_start = 1'b0;
    endtask

    // One beat: wait (bounded) for ready, hand it over, then check the write it caused.
    task automatic send_beat(input logic [63:0] d, input logic last, input logic exp_wr, input string tag);
        int guard;
        guard  = 0;
        tdata  = d;
        tlast  = last;
        tvalid = 1'b1;
        while (tready !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        chk({tag, " tready"}, 64'(tready), 64'd1);
        step();
        tvalid = 1'b0;
        tlast  = 1'b0;
        chk({tag, " wr_en"}, 64'(wr_en), 64'(exp_wr));
        if (exp_wr) chk({tag, " wr_data"}, wr_data, d);
    endtask

    task automatic send_range(input int from, input int to, input int last_idx,
                              input int wr_limit, input int gaps, input string tag);
        for (int i = from; i < to; i++) begin
            if (gaps != 0) repeat ($urandom_range(0, 2)) step();
            send_beat(64'(i), i == last_idx, i < wr_limit, tag);
        end
    endtask

    initial begin
        s_rst_n    = 1'b0;
        tdata      = '0;
        tvalid     = 1'b0;
        tlast      = 1'b0;
        data_count = '0;
        rx_start   = 1'b0;
        rx_len     = '0;
        #1;
        chk("reset tready", 64'(tready), 64'd0);
        chk("reset busy", 64'(rx_busy), 64'd0);
        chk("reset wr_data", wr_data, 64'd0);
        step();
        step();
        s_rst_n = 1'b1;
        step();

        start(0);
        chk("len0 ignored busy", 64'(rx_busy), 64'd0);
        chk("len0 ignored tready", 64'(tready), 64'd0);

        // 1: nominal 16-beat frame
        w0 = wr_cnt; f0 = fin_cnt;
        start(16);
        chk("t1 busy", 64'(rx_busy), 64'd1);
        chk("t1 tready", 64'(tready), 64'd1);
        send_range(0, 16, 15, 16, 0, "t1");
        chk("t1 finish", 64'(write_finish), 64'd1);
        chk("t1 len_err", 64'(len_err), 64'd0);
        chk("t1 busy in done", 64'(rx_busy), 64'd1);
        step();
        chk("t1 finish off", 64'(write_finish), 64'd0);
        chk("t1 busy off", 64'(rx_busy), 64'd0);
        chk("t1 tready off", 64'(tready), 64'd0);
        step();
        chk("t1 writes", 64'(wr_cnt - w0), 64'd16);
        chk("t1 finishes", 64'(fin_cnt - f0), 64'd1);

        // 2: backpressure from buffer fill
        w0 = wr_cnt;
        start(32);
        send_range(0, 10, -1, 32, 0, "t2a");
        data_count = 13'd4090;
        send_range(10, 12, -1, 32, 0, "t2b");
        chk("t2 tready low", 64'(tready), 64'd0);
        step(); step(); step();
        chk("t2 tready held", 64'(tready), 64'd0);
        data_count = 13'd100;
        send_range(12, 32, 31, 32, 0, "t2c");
        chk("t2 finish", 64'(write_finish), 64'd1);
        chk("t2 len_err", 64'(len_err), 64'd0);
        step(); step();
        chk("t2 writes", 64'(wr_cnt - w0), 64'd32);

        // 3: early tlast
        w0 = wr_cnt; f0 = fin_cnt;
        start(16);
        send_range(0, 10, 9, 16, 0, "t3");
        chk("t3 finish", 64'(write_finish), 64'd1);
        chk("t3 len_err", 64'(len_err), 64'd1);
        step();
        chk("t3 busy off", 64'(rx_busy), 64'd0);
        chk("t3 len_err sticky", 64'(len_err), 64'd1);
        step(); step();
        chk("t3 len_err still", 64'(len_err), 64'd1);
        chk("t3 writes", 64'(wr_cnt - w0), 64'd10);
        chk("t3 finishes", 64'(fin_cnt - f0), 64'd1);

        // 4: missing tlast, surplus beats drained
        w0 = wr_cnt; f0 = fin_cnt;
        start(8);
        send_range(0, 8, -1, 8, 0, "t4a");
        chk("t4 drain tready", 64'(tready), 64'd1);
        chk("t4 len_err early", 64'(len_err), 64'd1);
        chk("t4 no finish yet", 64'(write_finish), 64'd0);
        send_range(8, 12, 11, 8, 0, "t4b");
        chk("t4 finish", 64'(write_finish), 64'd1);
        chk("t4 len_err", 64'(len_err), 64'd1);
        step(); step();
        chk("t4 writes", 64'(wr_cnt - w0), 64'd8);
        chk("t4 finishes", 64'(fin_cnt - f0), 64'd1);

        // 5: gapped 64-beat frame with a stray rx_start
        w0 = wr_cnt;
        start(64);
        chk("t5 len_err cleared", 64'(len_err), 64'd0);
        send_range(0, 20, -1, 64, 1, "t5a");
        rx_start = 1'b1;
        rx_len   = 13'd5;
        step();
        rx_start = 1'b0;
        rx_len   = 13'd64;
        send_range(20, 64, 63, 64, 1, "t5b");
        chk("t5 finish", 64'(write_finish), 64'd1);
        chk("t5 len_err", 64'(len_err), 64'd0);
        step(); step();
        chk("t5 writes", 64'(wr_cnt - w0), 64'd64);
        chk("t5 busy off", 64'(rx_busy), 64'd0);

        // 6: asynchronous reset mid-frame, then a clean short frame
        start(16);
        send_range(0, 5, -1, 16, 0, "t6a");
        #2;
        s_rst_n = 1'b0;
        #1;
        chk("t6 rst wr_en", 64'(wr_en), 64'd0);
        chk("t6 rst wr_data", wr_data, 64'd0);
        chk("t6 rst tready", 64'(tready), 64'd0);
        chk("t6 rst busy", 64'(rx_busy), 64'd0);
        step();
        s_rst_n = 1'b1;
        step();
        chk("t6 idle after rst", 64'(rx_busy), 64'd0);
        w0 = wr_cnt; f0 = fin_cnt;
        start(4);
        send_range(0, 4, 3, 4, 0, "t6b");
        chk("t6 finish", 64'(write_finish), 64'd1);
        chk("t6 len_err", 64'(len_err), 64'd0);
        step(); step();
        chk("t6 writes", 64'(wr_cnt - w0), 64'd4);
        chk("t6 finishes", 64'(fin_cnt - f0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_rx.md
Name: stream_rx

Overview:
AXI4-Stream receiver for the MM2S side of the DMA path. It accepts 64-bit beats from the DMA MM2S master and writes them into the local frame buffer FIFO. It checks received frame length against a programmed beat count, applies backpressure from the buffer fill level, and reports completion and length errors to the control FSM.

Parameters:
DATA_W, 64, stream and buffer data width
CNT_W, 13, width of beat counter, rx_len and buffer_data_count
BUF_DEPTH, 4096, buffer FIFO depth in beats
AFULL_MARGIN, 8, free-entry margin below which tready is withdrawn

Ports:
sclk  input  1  system clock
s_rst_n  input  1  asynchronous active-low reset
m_axis_mm2s_tdata  input  DATA_W  stream data from DMA
m_axis_mm2s_tvalid  input  1  stream valid
m_axis_mm2s_tready  output  1  stream ready (registered)
m_axis_mm2s_tlast  input  1  last beat of frame
buffer_wr_en  output  1  buffer write strobe (registered)
buffer_wr_data  output  DATA_W  buffer write data (registered)
buffer_data_count  input  CNT_W  current buffer fill level
rx_start  input  1  single-cycle pulse: arm reception of one frame
rx_len  input  CNT_W  expected beats per frame, sampled on rx_start
rx_busy  output  1  high in any state except IDLE
write_finish  output  1  single-cycle frame-complete pulse
len_err  output  1  sticky length mismatch, cleared on accepted rx_start

Behaviour:
- Reset (async, s_rst_n=0): state=IDLE; tready, buffer_wr_en, write_finish, len_err, rx_busy = 0; buffer_wr_data = 0; beat_cnt = 0.
- States: IDLE, RECV, DRAIN, DONE.
- IDLE: on rx_start with rx_len != 0, latch rx_len, clear beat_cnt and len_err, go to RECV. rx_start with rx_len == 0 is ignored. rx_start outside IDLE is ignored.
- afull is registered: afull = (buffer_data_count >= BUF_DEPTH - AFULL_MARGIN).
- tready is registered. In RECV it is 1 when !afull, and it drops to 0 on the same edge the accepting beat moves the FSM out of RECV. In DRAIN it is 1 unconditionally. In IDLE and DONE it is 0.
- Handshake: a beat is accepted when tvalid & tready. tvalid may toggle freely and gaps are legal.
- RECV, per accepted beat:
  - Next cycle: buffer_wr_en=1 and buffer_wr_data=tdata (1-cycle latency).
  - beat_cnt increments.
- RECV termination, evaluated on the accepted beat:
  - tlast=1 and beat_cnt+1 == rx_len: go to DONE, len_err stays 0.
  - tlast=1 and beat_cnt+1 < rx_len (early last): len_err=1, go to DONE.
  - tlast=0 and beat_cnt+1 == rx_len (missing last): len_err=1, go to DRAIN.
- DRAIN: accept and discard beats with no buffer writes. On an accepted tlast, go to DONE.
- DONE: lasts one cycle, then IDLE. write_finish=1 in the DONE cycle, which coincides with the final buffer_wr_en when arriving from RECV.
- Width rules: beat_cnt is CNT_W bits, unsigned. rx_len range is 1..2^CNT_W-1. Comparisons are unsigned with no wrap; beat_cnt never exceeds rx_len.
- The margin AFULL_MARGIN must be at least 3, covering registered afull plus registered tready: at most 2 beats land after the threshold is crossed.
- Reset mid-frame: immediate return to reset values. Partially written buffer content is not the block's concern.

Decomposition:
- Shared package stream_pkg holds: state encoding constants (IDLE/RECV/DRAIN/DONE), the DATA_W/CNT_W defaults, and the AFULL_MARGIN minimum.
- No sub-module. The FSM, counter and output registers live in one module.

Test Plan:
1. rx_len=16; 16 back-to-back beats, data 0..15, tlast on beat 16 -> 16 buffer_wr_en pulses with data 0..15 in order, each 1 cycle after its handshake; write_finish=1 for one cycle coincident with the 16th write; len_err=0; rx_busy falls the cycle after.
2. BUF_DEPTH=4096, MARGIN=8; buffer_data_count driven to 4090 mid-frame -> tready low within 2 cycles, no beat lost or duplicated; count back to 100 -> tready returns and the frame completes with an exact beat count.
3. rx_len=16; tlast on beat 10 -> 10 writes, len_err=1 (sticky), write_finish pulses once, state back to IDLE.
4. rx_len=8; source sends 12 beats with tlast on beat 12 -> exactly 8 writes; beats 9..12 accepted with tready=1 and not written; len_err=1; write_finish on the cycle after beat 12.
5. rx_len=64 with random tvalid gaps, plus rx_start pulsed mid-frame -> mid-frame rx_start ignored; 64 correct writes; a following rx_start clears len_err and starts a new frame.
6. Reset asserted after 5 beats of a 16-beat frame -> all outputs 0 asynchronously, state IDLE; the next rx_start with a 4-beat frame completes normally with len_err=0.
